ecc_apb_job_master: RTL and testbench

Upstream driver for the ECC encoder/decoder APB slave. Accepts one job at a time (operation, codeword width, data, noise) on a valid/ready port and runs the APB register-write sequence, writing CTRL last because the CTRL write starts the operation. It then waits for `operation_done`, captures `data_out` and `num_of_errors`, and presents them on a valid/ready result port with a status code. A watchdog bounds the wait.

---
 rtl/ecc_apb_job_master_if.sv | 43 ++++
 rtl/ecc_apb_job_master.sv | 182 ++++++++++++++++++
 tb/tb_ecc_apb_job_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_job_master_if.sv
// Job, APB, slave-status and result signals of the ECC APB job master.
// The master modport is the job master itself; the slave modport is the
// environment (job source, APB slave, result consumer).
interface ecc_apb_job_master_if #(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32
);
   logic                       job_valid;
   logic                       job_ready;
   logic [1:0]                 job_ctrl;
   logic [1:0]                 job_width;
   logic [AMBA_WORD-1:0]       job_data;
   logic [AMBA_WORD-1:0]       job_noise;
   logic [AMBA_ADDR_WIDTH-1:0] PADDR;
   logic [AMBA_WORD-1:0]       PWDATA;
   logic                       PSEL;
   logic                       PENABLE;
   logic                       PWRITE;
   logic                       operation_done;
   logic [DATA_WIDTH-1:0]      data_out;
   logic [1:0]                 num_of_errors;
   logic                       res_valid;
   logic                       res_ready;
   logic [DATA_WIDTH-1:0]      res_data;
   logic [1:0]                 res_errors;
   logic [1:0]                 res_status;
   logic [15:0]                job_count;

   modport master (
      input  job_valid, job_ctrl, job_width, job_data, job_noise,
      input  operation_done, data_out, num_of_errors, res_ready,
      output job_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
      output res_valid, res_data, res_errors, res_status, job_count
   );

   modport slave (
      output job_valid, job_ctrl, job_width, job_data, job_noise,
      output operation_done, data_out, num_of_errors, res_ready,
      input  job_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
      input  res_valid, res_data, res_errors, res_status, job_count
   );
endinterface

// File: rtl/ecc_apb_job_master.sv
// ECC APB job master: takes one job, writes the slave registers over APB
// (CTRL last, since that write starts the slave), waits for operation_done
// under a watchdog and presents the captured result.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a job
// S_SETUP     | APB setup phase for register index idx_q
// S_ACCESS    | APB access phase for register index idx_q
// S_WAIT_DONE | waiting for operation_done, watchdog counting down
// S_RESULT    | result presented until res_ready
module ecc_apb_job_master #(
   parameter int                         AMBA_ADDR_WIDTH = 20,
   parameter int                         AMBA_WORD       = 32,
   parameter int                         DATA_WIDTH      = 32,
   parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                         TIMEOUT         = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   ecc_apb_job_master_if.master  bus
);
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ACCESS, S_WAIT_DONE, S_RESULT
   } state_t;

   state_t                     state, state_nxt;
   logic [1:0]                 ctrl_q;
   logic [AMBA_WORD-1:0]       data_q, noise_q;
   logic [1:0]                 idx_q, idx_nxt;
   logic [WD_W-1:0]            wd_q;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_nxt;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_nxt;
   logic [DATA_WIDTH-1:0]      res_data_q;
   logic [1:0]                 res_errors_q, res_status_q;
   logic [15:0]                job_count_q;
   logic                       ld_job, ld_apb, wd_ld;
   logic                       cap_done, cap_to, cap_ill, cnt_inc;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next state and datapath strobes; index 2 (NOISE) only for full channel
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx_q;
      ld_job    = 1'b0;
      ld_apb    = 1'b0;
      wd_ld     = 1'b0;
      cap_done  = 1'b0;
      cap_to    = 1'b0;
      cap_ill   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.job_valid) begin
               ld_job = 1'b1;
               if (bus.job_ctrl == 2'b11) begin
                  cap_ill   = 1'b1;
                  state_nxt = S_RESULT;
               end else begin
                  ld_apb    = 1'b1;
                  idx_nxt   = 2'd0;
                  state_nxt = S_SETUP;
               end
            end
         end
         S_SETUP: state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (idx_q == 2'd3) begin
               wd_ld     = 1'b1;
               state_nxt = S_WAIT_DONE;
            end else begin
               ld_apb    = 1'b1;
               idx_nxt   = (idx_q == 2'd1 && ctrl_q != 2'b10) ? 2'd3 : idx_q + 2'd1;
               state_nxt = S_SETUP;
            end
         end
         S_WAIT_DONE: begin
            if (bus.operation_done) begin
               cap_done  = 1'b1;
               state_nxt = S_RESULT;
            end else if (wd_q == '0) begin
               cap_to    = 1'b1;
               state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            if (bus.res_ready) begin
               cnt_inc   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Register address/data for the index about to be set up; width comes
   // straight from the handshake because index 0 is only loaded from IDLE
   always_comb begin
      paddr_nxt  = BASE_ADDR;
      pwdata_nxt = '0;
      case (idx_nxt)
         2'd0: begin
            paddr_nxt  = BASE_ADDR + AMBA_ADDR_WIDTH'(8);
            pwdata_nxt = AMBA_WORD'(bus.job_width);
         end
         2'd1: begin
            paddr_nxt  = BASE_ADDR + AMBA_ADDR_WIDTH'(4);
            pwdata_nxt = data_q;
         end
         2'd2: begin
            paddr_nxt  = BASE_ADDR + AMBA_ADDR_WIDTH'(12);
            pwdata_nxt = noise_q;
         end
         default: begin
            paddr_nxt  = BASE_ADDR;
            pwdata_nxt = AMBA_WORD'(ctrl_q);
         end
      endcase
   end

   // Job latch, APB address/data hold, watchdog down-counter, result capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q       <= '0;
         data_q       <= '0;
         noise_q      <= '0;
         idx_q        <= '0;
         wd_q         <= '0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         res_data_q   <= '0;
         res_errors_q <= '0;
         res_status_q <= '0;
         job_count_q  <= '0;
      end else begin
         if (ld_job) begin
            ctrl_q  <= bus.job_ctrl;
            data_q  <= bus.job_data;
            noise_q <= bus.job_noise;
         end
         if (ld_apb) begin
            idx_q    <= idx_nxt;
            paddr_q  <= paddr_nxt;
            pwdata_q <= pwdata_nxt;
         end
         if (wd_ld)
            wd_q <= WD_W'(TIMEOUT - 1);
         else if (state == S_WAIT_DONE && wd_q != '0)
            wd_q <= wd_q - 1'b1;
         if (cap_done) begin
            res_data_q   <= bus.data_out;
            res_errors_q <= bus.num_of_errors;
            res_status_q <= 2'b00;
         end else if (cap_to || cap_ill) begin
            res_data_q   <= '0;
            res_errors_q <= '0;
            res_status_q <= cap_to ? 2'b01 : 2'b10;
         end
         if (cnt_inc)
            job_count_q <= job_count_q + 16'd1;
      end
   end

   assign bus.job_ready  = (state == S_IDLE);
   assign bus.PSEL       = (state == S_SETUP) || (state == S_ACCESS);
   assign bus.PENABLE    = (state == S_ACCESS);
   assign bus.PWRITE     = bus.PSEL;
   assign bus.PADDR      = paddr_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.res_valid  = (state == S_RESULT);
   assign bus.res_data   = res_data_q;
   assign bus.res_errors = res_errors_q;
   assign bus.res_status = res_status_q;
   assign bus.job_count  = job_count_q;
endmodule

// File: tb/tb_ecc_apb_job_master.sv
// Directed bench for ecc_apb_job_master with APB-write and result scoreboards.
module tb_ecc_apb_job_master;
   localparam int AW = 20;
   localparam int AWD = 32;
   localparam int DW = 32;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ecc_apb_job_master_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(AWD), .DATA_WIDTH(DW)) bus();

   ecc_apb_job_master #(
      .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(AWD), .DATA_WIDTH(DW),
      .BASE_ADDR(20'h0), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct { logic [31:0] addr; logic [31:0] data; } apb_t;
   typedef struct { logic [31:0] data; logic [1:0] err; logic [1:0] st; logic [15:0] cnt; } res_t;

   apb_t apb_q[$];
   res_t res_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pen_cnt = 0;
   int psel_cnt = 0;
   int last_acc = 0;
   int exp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // APB monitor: every access phase must match the next expected write
   always @(negedge clk) begin
      apb_t e;
      if (bus.PSEL) psel_cnt++;
      if (bus.PSEL && bus.PENABLE) begin
         pen_cnt++;
         last_acc = cyc;
         if (apb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL apb_unexpected: got addr 0x%0h data 0x%0h, none expected", bus.PADDR, bus.PWDATA);
         end else begin
            e = apb_q.pop_front();
            chk("apb_addr", 32'(bus.PADDR), e.addr);
            chk("apb_data", bus.PWDATA, e.data);
            chk("apb_pwrite", 32'(bus.PWRITE), 32'd1);
         end
      end
   end

   // Result monitor: compare on every accepted result
   always @(negedge clk) begin
      res_t e;
      if (bus.res_valid && bus.res_ready) begin
         if (res_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_unexpected: got data 0x%0h status %0d, none expected", bus.res_data, bus.res_status);
         end else begin
            e = res_q.pop_front();
            chk("res_data", bus.res_data, e.data);
            chk("res_errors", 32'(bus.res_errors), 32'(e.err));
            chk("res_status", 32'(bus.res_status), 32'(e.st));
            chk("res_job_count", 32'(bus.job_count), 32'(e.cnt));
         end
      end
   end

   task automatic push_apb(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d, input logic [31:0] n);
      apb_q.push_back('{32'h8, 32'(w)});
      apb_q.push_back('{32'h4, d});
      if (c == 2'b10) apb_q.push_back('{32'hC, n});
      apb_q.push_back('{32'h0, 32'(c)});
   endtask

   task automatic push_res(input logic [31:0] d, input logic [1:0] e, input logic [1:0] s);
      res_q.push_back('{d, e, s, 16'(exp_cnt)});
      exp_cnt++;
   endtask

   // Offer a job; returns the cycle number of the handshake edge
   task automatic send_job(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                           input logic [31:0] n, output int e0);
      logic r;
      bit got;
      got = 0;
      @(posedge clk); #1;
      bus.job_valid = 1'b1;
      bus.job_ctrl  = c;
      bus.job_width = w;
      bus.job_data  = d;
      bus.job_noise = n;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         r = bus.job_ready;
         @(posedge clk); #1;
         if (r) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL job_handshake_timeout: got no job_ready, required within 50 cycles");
      end
      bus.job_valid = 1'b0;
      e0 = cyc;
   endtask

   task automatic run_done(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                           input logic [31:0] n, input logic [31:0] dout, input logic [1:0] ne,
                           input int acc_ofs, input int hold);
      int e0;
      push_apb(c, w, d, n);
      push_res(dout, ne, 2'b00);
      if (hold > 0) bus.res_ready = 1'b0;
      send_job(c, w, d, n, e0);
      while (cyc < e0 + acc_ofs + 1) begin
         @(posedge clk); #1;
      end
      chk("last_access_offset", 32'(last_acc - e0), 32'(acc_ofs));
      bus.operation_done = 1'b1;
      bus.data_out       = dout;
      bus.num_of_errors  = ne;
      @(posedge clk); #1;
      bus.operation_done = 1'b0;
      chk("res_valid_after_done", 32'(bus.res_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
         chk("hold_job_ready", 32'(bus.job_ready), 32'd0);
         chk("hold_res_data", bus.res_data, dout);
         chk("hold_res_errors", 32'(bus.res_errors), 32'(ne));
         chk("hold_res_status", 32'(bus.res_status), 32'd0);
         if (i == 1) begin
            bus.operation_done = 1'b1;
            bus.data_out       = 32'h99;
            bus.num_of_errors  = 2'b01;
         end else begin
            bus.operation_done = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.operation_done = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      chk("job_count_after", 32'(bus.job_count), 32'(exp_cnt));
   endtask

   initial begin
      int e0;
      int p0;
      int n;
      bus.job_valid      = 1'b0;
      bus.job_ctrl       = 2'b00;
      bus.job_width      = 2'b00;
      bus.job_data       = '0;
      bus.job_noise      = '0;
      bus.operation_done = 1'b0;
      bus.data_out       = '0;
      bus.num_of_errors  = 2'b00;
      bus.res_ready      = 1'b1;

      @(posedge clk); @(posedge clk); #1;
      chk("rst_job_ready", 32'(bus.job_ready), 32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_psel", 32'(bus.PSEL), 32'd0);
      chk("rst_penable", 32'(bus.PENABLE), 32'd0);
      chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
      chk("rst_paddr", 32'(bus.PADDR), 32'd0);
      chk("rst_pwdata", bus.PWDATA, 32'd0);
      chk("rst_job_count", 32'(bus.job_count), 32'd0);
      chk("rst_res_status", 32'(bus.res_status), 32'd0);
      rst = 1'b1;

      // Encode, width 8
      run_done(2'b00, 2'b00, 32'h0000_000B, 32'h0, 32'h5A, 2'b00, 5, 0);

      // Full channel, width 16, one error reported
      p0 = pen_cnt;
      run_done(2'b10, 2'b01, 32'h0000_1234, 32'h0000_0004, 32'h0000_ABCD, 2'b01, 7, 0);
      chk("full_penable_cycles", 32'(pen_cnt - p0), 32'd4);

      // Decode with no operation_done: watchdog expiry
      push_apb(2'b01, 2'b10, 32'hDEAD_BEEF, 32'h0);
      push_res(32'h0, 2'b00, 2'b01);
      send_job(2'b01, 2'b10, 32'hDEAD_BEEF, 32'h0, e0);
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (bus.res_valid) begin
            n = k;
            break;
         end
      end
      chk("timeout_latency", 32'(n), 32'd70);
      @(posedge clk); #1;
      chk("timeout_job_count", 32'(bus.job_count), 32'(exp_cnt));

      // Illegal ctrl: no APB traffic, immediate result
      p0 = psel_cnt;
      push_res(32'h0, 2'b00, 2'b10);
      send_job(2'b11, 2'b00, 32'h5555_5555, 32'h1, e0);
      chk("illegal_res_valid", 32'(bus.res_valid), 32'd1);
      @(posedge clk); #1;
      chk("illegal_psel_cycles", 32'(psel_cnt - p0), 32'd0);
      chk("illegal_job_count", 32'(bus.job_count), 32'(exp_cnt));

      // Back-pressure on the result with a spurious operation_done
      run_done(2'b00, 2'b00, 32'h7, 32'h0, 32'h33, 2'b10, 5, 5);

      // Reset in the access phase of the DATA_IN write
      apb_q.push_back('{32'h8, 32'h1});
      send_job(2'b00, 2'b01, 32'h1, 32'h0, e0);
      while (cyc < e0 + 3) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
      chk("pre_rst_paddr", 32'(bus.PADDR), 32'h4);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_psel", 32'(bus.PSEL), 32'd0);
      chk("rst_mid_penable", 32'(bus.PENABLE), 32'd0);
      chk("rst_mid_job_count", 32'(bus.job_count), 32'd0);
      chk("rst_mid_res_valid", 32'(bus.res_valid), 32'd0);
      exp_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      run_done(2'b00, 2'b01, 32'h1, 32'h0, 32'h11, 2'b00, 5, 0);

      chk("apb_queue_empty", 32'(apb_q.size()), 32'd0);
      chk("res_queue_empty", 32'(res_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule
